// File: rtl/simd_alu_pipe_pkg.sv
// Shared opcode encodings and lane-mask helper for the SIMD ALU pipeline.
// Opcode values match the processor Opcode field.
package simd_alu_pipe_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDV  = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SHIFT = 4'h5;
    localparam logic [3:0] OP_ANY   = 4'hA;
    localparam logic [3:0] OP_ANYV  = 4'hB;
    localparam logic [3:0] OP_NEG   = 4'hC;
    localparam logic [3:0] OP_NEGV  = 4'hD;

    localparam int MASK_MAX_W = 1024;

    // One bit set at the MSB of every lane; callers truncate to their width.
    function automatic logic [MASK_MAX_W-1:0] lane_msb_mask(input int lane_w);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX_W; i++)
            m[i] = ((i % lane_w) == (lane_w - 1));
        return m;
    endfunction

endpackage

// File: rtl/simd_alu_lane.sv
// Combinational per-lane signed adder/negator with optional saturation,
// plus a lane-nonzero flag.
module simd_alu_lane #(
    parameter int LANE_W = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum,
    output logic [LANE_W-1:0] neg,
    output logic              nz
);

    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] ONE  = {{(LANE_W-1){1'b0}}, 1'b1};

    logic [LANE_W-1:0] raw_sum, raw_neg;
    logic              ovf_sum, ovf_neg;

    always_comb begin
        raw_sum = a + b;
        raw_neg = ~a + ONE;
        // Signed overflow only when both operands share a sign the sum lost.
        ovf_sum = (a[LANE_W-1] == b[LANE_W-1]) && (raw_sum[LANE_W-1] != a[LANE_W-1]);
        ovf_neg = (a == SMIN);
        sum     = (SAT_EN && ovf_sum) ? (a[LANE_W-1] ? SMIN : SMAX) : raw_sum;
        neg     = (SAT_EN && ovf_neg) ? SMAX : raw_neg;
        nz      = |a;
    end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage valid/ready SIMD/scalar ALU: S1 latches the operation, S2 latches
// the computed result, tag and error flag.
module simd_alu_pipe
    import simd_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int TAG_W  = 4,
    parameter bit SAT_EN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int LANES = DATA_W / LANE_W;
    localparam logic [DATA_W-1:0] MSB_M = DATA_W'(lane_msb_mask(LANE_W));
    localparam logic [DATA_W-1:0] DW    = DATA_W'(DATA_W);

    generate
        if ((DATA_W % LANE_W) != 0 || LANE_W < 2 || DATA_W > MASK_MAX_W) begin : g_bad_cfg
            $error("simd_alu_pipe: DATA_W must be a multiple of LANE_W (LANE_W>=2)");
        end
    endgenerate

    logic              s1_valid, s2_valid, adv2, accept;
    logic [3:0]        s1_op;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [TAG_W-1:0]  s1_tag;

    assign adv2      = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || adv2;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    logic [LANES-1:0][LANE_W-1:0] a_l, b_l, sum_l, neg_l, anyv_l;
    logic [LANES-1:0]             nz_l;

    assign a_l = s1_a;
    assign b_l = s1_b;

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            simd_alu_lane #(.LANE_W(LANE_W), .SAT_EN(SAT_EN)) u_lane (
                .a   (a_l[l]),
                .b   (b_l[l]),
                .sum (sum_l[l]),
                .neg (neg_l[l]),
                .nz  (nz_l[l])
            );
            assign anyv_l[l] = {{(LANE_W-1){1'b0}}, nz_l[l]};
        end
    endgenerate

    logic [DATA_W-1:0] addv_swar, shamt, res;
    logic              shl, err;

    always_comb begin
        // Carry-cut lane add: sum low bits, then fix MSBs with a carry-free xor.
        addv_swar = ((s1_a & ~MSB_M) + (s1_b & ~MSB_M)) ^ ((s1_a ^ s1_b) & MSB_M);
        shl       = s1_b[DATA_W-1];
        shamt     = shl ? (~s1_b + {{(DATA_W-1){1'b0}}, 1'b1}) : s1_b;
        res       = '0;
        err       = 1'b0;
        case (s1_op)
            OP_ADD:   res = s1_a + s1_b;
            OP_ADDV:  res = SAT_EN ? sum_l : addv_swar;
            OP_AND:   res = s1_a & s1_b;
            OP_OR:    res = s1_a | s1_b;
            OP_XOR:   res = s1_a ^ s1_b;
            OP_SHIFT: res = (shamt >= DW) ? '0 : (shl ? (s1_a << shamt) : (s1_a >> shamt));
            OP_ANY:   res = {{(DATA_W-1){1'b0}}, |s1_a};
            OP_ANYV:  res = anyv_l;
            OP_NEG:   res = ~s1_a + {{(DATA_W-1){1'b0}}, 1'b1};
            OP_NEGV:  res = neg_l;
            default:  err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            out_data <= res;
            out_tag  <= s1_tag;
            out_err  <= err;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench: wrapping and saturating instances share one input stream;
// expected results are queued at issue and checked as outputs are consumed.
module tb_simd_alu_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        rdy0, rdy1, ov0, ov1, er0, er1;
    logic [31:0] od0, od1;
    logic [3:0]  ot0, ot1;

    always #5 clk = ~clk;

    simd_alu_pipe #(.DATA_W(32), .LANE_W(8), .TAG_W(4), .SAT_EN(1'b0)) d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_tag(ot0), .out_err(er0));

    simd_alu_pipe #(.DATA_W(32), .LANE_W(8), .TAG_W(4), .SAT_EN(1'b1)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_tag(ot1), .out_err(er1));

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [3:0]  tag;
        logic        err;
        logic        lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic err, input logic lat);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        while (1) begin
            @(negedge clk);
            if (rdy0) break;
            n++;
            if (n > 50) begin
                chk("issue_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        e.e0 = e0; e.e1 = e1; e.tag = tag; e.err = err; e.lat = lat; e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] hold0, hold1;
    logic [3:0]  hold_tag;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ov0) begin
                chk("stall_data0", od0, hold0);
                chk("stall_data1", od1, hold1);
                chk("stall_tag", {28'd0, ot0}, {28'd0, hold_tag});
            end
            if (ov0 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("stale_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_wrap", od0, e.e0);
                    chk("data_sat", od1, e.e1);
                    chk("tag", {28'd0, ot0}, {28'd0, e.tag});
                    chk("err", {31'd0, er0}, {31'd0, e.err});
                    chk("valid_sat", {31'd0, ov1}, 32'd1);
                    if (e.lat) chk("latency", 32'(cyc + 1 - e.acc), 32'd2);
                end
            end
            prev_stall = ov0 && !out_ready;
            hold0 = od0; hold1 = od1; hold_tag = ot0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic saw_drop;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ov0}, 32'd0);
        chk("rst_data", od0, 32'd0);
        chk("rst_tag", {28'd0, ot0}, 32'd0);
        chk("rst_err", {31'd0, er0}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, rdy0}, 32'd1);

        // Reset with two ops in flight discards both.
        out_ready = 1'b0;
        issue(4'h0, 32'd1, 32'd1, 4'd1, 32'd2, 32'd2, 1'b0, 1'b0);
        issue(4'h0, 32'd2, 32'd2, 4'd2, 32'd4, 32'd4, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        chk("midrst_valid", {31'd0, ov0}, 32'd0);
        chk("midrst_data", od0, 32'd0);
        chk("midrst_valid_sat", {31'd0, ov1}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, rdy0}, 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // Lane add: wrap vs saturate.
        issue(4'h1, 32'h7F01FF80, 32'h01FF0180, 4'd3, 32'h80000000, 32'h7F000080, 1'b0, 1'b1);
        drain();

        // Shift both directions and out-of-range amounts.
        issue(4'h5, 32'h80000001, -32'sd4,  4'd4, 32'h00000010, 32'h00000010, 1'b0, 1'b1);
        issue(4'h5, 32'h80000001, 32'd4,    4'd5, 32'h08000000, 32'h08000000, 1'b0, 1'b0);
        issue(4'h5, 32'h80000001, 32'd32,   4'd6, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(4'h5, 32'h80000001, -32'sd40, 4'd7, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reductions, negation, bitwise.
        issue(4'hB, 32'h00120000, 32'h0, 4'd8,  32'h00010000, 32'h00010000, 1'b0, 1'b0);
        issue(4'hA, 32'h0,        32'h0, 4'd9,  32'h0, 32'h0, 1'b0, 1'b0);
        issue(4'hA, 32'h00000100, 32'h0, 4'd10, 32'h1, 32'h1, 1'b0, 1'b0);
        issue(4'hD, 32'h0180FF00, 32'h0, 4'd11, 32'hFF800100, 32'hFF7F0100, 1'b0, 1'b0);
        issue(4'hC, 32'h00000001, 32'h0, 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(4'h0, 32'hFFFFFFFF, 32'h1, 4'd13, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd1, 32'hF000_F000, 32'hF000_F000, 1'b0, 1'b0);
        issue(4'h3, 32'hF0F0_F0F0, 32'h0F00_0000, 4'd2, 32'hFFF0_F0F0, 32'hFFF0_F0F0, 1'b0, 1'b0);
        issue(4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 1'b0, 1'b0);
        drain();

        // Back-to-back adds with an output stall in the middle.
        saw_drop = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(4'h0, 32'(i), 32'd1, 4'(i), 32'(i + 1), 32'(i + 1), 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (!rdy0) saw_drop = 1'b1;
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_drop", {31'd0, saw_drop}, 32'd1);

        // Unsupported opcodes, then recovery.
        issue(4'h7, 32'h12345678, 32'h1, 4'd5, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(4'hF, 32'hFFFFFFFF, 32'h1, 4'd9, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(4'h0, 32'd3, 32'd4, 4'd6, 32'd7, 32'd7, 1'b0, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
